x_write_arbiter: RTL
====================

X_WRITE_ARBITER -- requirements
Module: x_write_arbiter

Interface
REQ-001 Ports SHALL be, in this order:
- clk  input  1  sole clock, rising edge.
- rst_b  input  1  asynchronous, active-low reset.
- req  input  4  per-requester write request; bit i = requester i.
- lock  input  4  per-requester burst hold; qualifies req of the current owner.
- wdata  input  64  flattened write data; requester i at bits [16*i+15:16*i].
- gnt  output  4  registered one-hot grant; all zero when idle.
- ack  output  4  one-hot write-commit strobe to the owner.
- reg_en  output  1  write enable to the shared 16-bit register.
- reg_d  output  16  data to the shared 16-bit register.
- busy  output  1  high while in WRITE.
REQ-002 Parameters SHALL be:
- NUM_REQ, default 4, number of requesters.
- WIDTH, default 16, data width.
- MAX_BURST, default 4, maximum consecutive writes by a locked owner.

Function
REQ-003 The block SHALL implement a two-state FSM with states IDLE and WRITE.
REQ-004 Arbitration SHALL be round-robin: the winner is the first requester with req high, searching upward from (last+1) mod NUM_REQ.
REQ-005 In IDLE with any req high, the next edge SHALL load state to WRITE, owner to the winner, data_q to the winner's wdata, gnt to onehot(winner), last to the winner, and burst to 1.
REQ-006 In IDLE with no req high, the block SHALL hold state, and gnt SHALL be 0.
REQ-007 In WRITE, outputs SHALL be combinational from state: reg_en=1, reg_d=data_q, ack=gnt, busy=1.
REQ-008 In IDLE, reg_en, ack and busy SHALL be 0, and reg_d SHALL equal data_q.
REQ-009 Latency SHALL be: req seen in IDLE in cycle N, reg_en high in cycle N+1, shared register updated at the end of cycle N+1.
REQ-010 During its ack cycle, a requester holding req high SHALL be requesting a further write with new wdata presented in that same cycle.
REQ-011 In WRITE, if lock[owner], req[owner] and burst<MAX_BURST are all high, the next edge SHALL stay in WRITE, capture owner wdata, keep gnt, and increment burst.
REQ-012 Otherwise in WRITE, if any req is high, the block SHALL re-arbitrate per REQ-004/REQ-005 with no idle cycle; the owner may win again, restarting burst at 1.
REQ-013 Otherwise in WRITE, the next edge SHALL go to IDLE with gnt=0.
REQ-014 Sustained throughput SHALL be one write per cycle.
REQ-015 Once captured, data SHALL be committed even if the owner drops req during the WRITE cycle.
REQ-016 lock on a non-owner SHALL be ignored.
REQ-017 burst SHALL saturate at MAX_BURST and SHALL never wrap.
REQ-018 gnt and ack SHALL always be one-hot or zero.

Reset
REQ-019 With rst_b low, the block SHALL asynchronously set state=IDLE, gnt=0, data_q=0, burst=0 and last=NUM_REQ-1, so that requester 0 has first priority.
REQ-020 Consequently all outputs SHALL read 0 during reset, including reset asserted mid-WRITE; an in-flight write is discarded and not acknowledged.
REQ-021 The first arbitration SHALL occur on the first rising edge after rst_b is released.

Structure
REQ-022 The shared package proc_arb_pkg SHALL hold NUM_REQ, WIDTH, MAX_BURST and the state encoding (IDLE=0, WRITE=1).
REQ-023 Round-robin selection SHALL be a combinational sub-module rr_pick with inputs req and last, and outputs valid and idx.
REQ-024 All sequential logic SHALL reside in x_write_arbiter.

Verification
REQ-025 Single write: req=0001, wdata0=0x1234 for one cycle -> next cycle gnt=0001, reg_en=1, reg_d=0x1234, ack=0001; following cycle IDLE, all outputs 0.
REQ-026 Round-robin: req=1111 held, lock=0 -> gnt sequence 0001, 0010, 0100, 1000, 0001 on consecutive cycles, reg_en continuously 1.
REQ-027 Burst cap: req1 held with lock1=1 and data 0xA0..0xA4, req2 held -> writes by 1,1,1,1,2 (data A0..A3, then req2 data), then requester 1 again.
REQ-028 Mid-write reset: rst_b pulled low during WRITE -> gnt, reg_en, ack go 0 without a clock edge; after release, req=1001 -> requester 0 wins.
REQ-029 Dropped request: owner deasserts req in its ack cycle, data 0x5A5A -> reg_d=0x5A5A written once, then IDLE.
REQ-030 Non-owner lock: lock=0100 with req=0011 -> requester 2 is never granted, and grants alternate between requesters 0 and 1.

Source files
------------

// File: rtl/proc_arb_pkg.sv
// Shared constants and state encoding for the write arbiter.
//   NUM_REQ   : number of requesters
//   WIDTH     : write data width
//   MAX_BURST : longest run of consecutive writes a locked owner may hold
package proc_arb_pkg;
  localparam int NUM_REQ   = 4;
  localparam int WIDTH     = 16;
  localparam int MAX_BURST = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req   : request vector, bit i = requester i
//   last  : index of the most recent winner
//   valid : some request is pending
//   idx   : first requesting index searching upward from (last+1) mod N
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] p;

  // Scan from the farthest candidate down to the nearest so the nearest
  // requester after 'last' is the final assignment and wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    p     = '0;
    for (int k = N; k >= 1; k--) begin
      p = IW'((int'(last) + k) % N);
      if (req[p]) begin
        valid = 1'b1;
        idx   = p;
      end
    end
  end
endmodule

// File: rtl/x_write_arbiter.sv
// Round-robin arbiter granting NUM_REQ requesters access to one shared
// WIDTH-bit register, one write per cycle, with optional locked bursts.
//   clk, rst_b : clock, async active-low reset
//   req, lock  : per-requester request and burst hold
//   wdata      : flattened write data, requester i at [WIDTH*i +: WIDTH]
//   gnt        : registered one-hot grant
//   ack        : one-hot commit strobe to the owner (gnt while writing)
//   reg_en     : shared register write enable
//   reg_d      : shared register write data
//   busy       : high while in WRITE
module x_write_arbiter #(
  parameter int NUM_REQ   = proc_arb_pkg::NUM_REQ,
  parameter int WIDTH     = proc_arb_pkg::WIDTH,
  parameter int MAX_BURST = proc_arb_pkg::MAX_BURST
) (
  input  logic                     clk,
  input  logic                     rst_b,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       lock,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     reg_en,
  output logic [WIDTH-1:0]         reg_d,
  output logic                     busy
);
  import proc_arb_pkg::*;

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

  state_t                         state;
  logic   [IW-1:0]                owner, last;
  logic   [BW-1:0]                burst;
  logic   [WIDTH-1:0]             data_q;
  logic   [NUM_REQ-1:0][WIDTH-1:0] wd;
  logic                           pick_vld;
  logic   [IW-1:0]                pick_idx;
  logic                           keep;

  assign wd = wdata;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (req),
    .last  (last),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  // Locked owner keeps the register until it drops req/lock or hits the cap.
  assign keep = lock[owner] && req[owner] && (burst < BMAX);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state  <= IDLE;
      gnt    <= '0;
      data_q <= '0;
      burst  <= '0;
      owner  <= '0;
      last   <= IW'(NUM_REQ - 1);
    end else begin
      if (state == WRITE && keep) begin
        data_q <= wd[owner];
        burst  <= burst + BW'(1);
      end else if (pick_vld) begin
        // Same path from IDLE and WRITE: back-to-back writes, no bubble.
        state  <= WRITE;
        owner  <= pick_idx;
        last   <= pick_idx;
        data_q <= wd[pick_idx];
        gnt    <= NUM_REQ'(1) << pick_idx;
        burst  <= BW'(1);
      end else begin
        state <= IDLE;
        gnt   <= '0;
      end
    end
  end

  assign reg_en = (state == WRITE);
  assign busy   = (state == WRITE);
  assign ack    = (state == WRITE) ? gnt : '0;
  assign reg_d  = data_q;
endmodule
